// File: rtl/timer_counter_pkg.sv
// Shared constants for timer_counter: register word offsets, CTRL bit positions,
// MODE encodings and FSM state encodings.
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_PSC    = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    // Only auto-reload is distinguished; every other MODE value is one-shot.
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/tc_prescaler.sv
// Prescale counter for timer_counter: emits one tick per PSC+1 counting cycles.
// Only compiled when TC_PRESCALE_EN is defined.
`ifdef TC_PRESCALE_EN
module tc_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_run,
    input  logic [15:0] i_psc,
    output logic        o_tick
);

    logic [15:0] r_cnt;

    assign o_tick = i_run && (r_cnt == i_psc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Optional prescaler (PSC register at 0xC) enabled by macro TC_PRESCALE_EN.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;
    tc_state_e   r_state;

    tc_state_e   w_state_next;
    logic [31:0] w_count_next;
    logic        w_irq_flag_next;
    logic        w_en_clear;
    logic        w_tick;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_hold;
    logic        w_unused_addr;

    assign w_hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off         = addr[3:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_wr_ctrl     = we && w_hit && (w_off == TC_CTRL);
    assign w_wr_preset   = we && w_hit && (w_off == TC_PRESET);
    // A CTRL/PRESET store freezes the FSM for that cycle so the new value applies cleanly.
    assign w_hold        = w_wr_ctrl || w_wr_preset;

`ifdef TC_PRESCALE_EN
    logic [15:0] r_psc;
    logic        w_wr_psc;

    assign w_wr_psc = we && w_hit && (w_off == TC_PSC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psc <= '0;
        end else if (w_wr_psc) begin
            r_psc <= din[15:0];
        end
    end

    tc_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!w_hold && (r_state == ST_LOAD)),
        .i_run   (!w_hold && (r_state == ST_CNT)),
        .i_psc   (r_psc),
        .o_tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_irq_flag_next = r_irq_flag;
        w_en_clear      = 1'b0;
        if (!w_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[CTRL_EN]) begin
                        w_state_next    = ST_LOAD;
                        w_irq_flag_next = 1'b0;
                    end
                end
                ST_LOAD: begin
                    w_count_next = r_preset;
                    w_state_next = ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[CTRL_EN]) begin
                        w_state_next = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_count > 32'd1) begin
                            w_count_next = r_count - 32'd1;
                        end else begin
                            w_count_next    = '0;
                            w_irq_flag_next = 1'b1;
                            w_state_next    = ST_INT;
                        end
                    end
                end
                ST_INT: begin
                    w_state_next = ST_IDLE;
                    if (r_ctrl[CTRL_MODE +: 2] == MODE_RELOAD) begin
                        w_irq_flag_next = 1'b0;
                    end else begin
                        w_en_clear = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_irq_flag <= w_irq_flag_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_preset <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= din[3:0];
            end else if (w_en_clear) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= din;
            end
        end
    end

    assign irq = r_irq_flag & r_ctrl[CTRL_IM];

    always_comb begin
        dout = '0;
        if (w_hit) begin
            case (w_off)
                TC_CTRL:   dout = {28'd0, r_ctrl};
                TC_PRESET: dout = r_preset;
                TC_COUNT:  dout = r_count;
`ifdef TC_PRESCALE_EN
                TC_PSC:    dout = {16'd0, r_psc};
`else
                TC_PSC:    dout = '0;
`endif
            endcase
        end
    end

endmodule
